sample_expander: RTL and testbench

SAMPLE_EXPANDER -- requirements
Module: sample_expander

---
 rtl/fft_pkg.sv | 16 +
 rtl/sample_widen.sv | 15 +
 rtl/sample_expander.sv | 132 +++++++++++++
 tb/tb_sample_expander.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared sample types, default frame length and skid-buffer state encoding
// for the sample expansion path.
package fft_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic signed [31:0] wide_t;

    localparam int unsigned FFT_N_DEFAULT = 16;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } skid_state_t;

endpackage

// File: rtl/sample_widen.sv
// Combinational widening of a signed 16-bit sample to 32 bits, scaled by a
// left shift; SHIFT=16 undoes the 32->16 narrowing stage.
module sample_widen
    import fft_pkg::*;
#(
    parameter int unsigned SHIFT = 16
) (
    input  sample_t din,
    output wide_t   dout
);

    // Cast sign-extends before the shift; overflow bits simply fall off.
    assign dout = wide_t'(din) << SHIFT;

endmodule

// File: rtl/sample_expander.sv
// Widens 16-bit samples into 32-bit words through a 2-entry skid buffer.
// Define FRAME_LAST_EN to add the frame counter and the m_last output.
module sample_expander
    import fft_pkg::*;
#(
    parameter int unsigned FFT_N = FFT_N_DEFAULT,
    parameter int unsigned SHIFT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready
`ifdef FRAME_LAST_EN
    ,
    output logic        m_last
`endif
);

    skid_state_t state_q, state_d;
    wide_t       widened;
    wide_t       head_q, skid_q;
    logic        in_xfer, out_xfer;
    logic        head_new, skid_new, head_from_skid;

    sample_widen #(
        .SHIFT(SHIFT)
    ) u_widen (
        .din (sample_t'(s_data)),
        .dout(widened)
    );

    assign s_ready  = (state_q != FULL) && !rst;
    assign m_valid  = (state_q != EMPTY);
    assign m_data   = head_q;
    assign in_xfer  = s_valid && s_ready;
    assign out_xfer = m_valid && m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        head_new       = 1'b0;
        skid_new       = 1'b0;
        head_from_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    head_new = 1'b1;
                    state_d  = ONE;
                end
            end
            ONE: begin
                // Simultaneous pop and push replaces the head in place.
                if (in_xfer && out_xfer) begin
                    head_new = 1'b1;
                end else if (in_xfer) begin
                    skid_new = 1'b1;
                    state_d  = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    head_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (head_new) begin
                head_q <= widened;
            end else if (head_from_skid) begin
                head_q <= skid_q;
            end
            if (skid_new) begin
                skid_q <= widened;
            end
        end
    end

`ifdef FRAME_LAST_EN
    localparam int unsigned CNT_W = $clog2(FFT_N);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FFT_N - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             in_last;
    logic             head_last_q, skid_last_q;

    assign in_last = (cnt_q == CNT_MAX);
    assign m_last  = head_last_q;

    // FFT_N is a power of two, so the natural wrap is the frame wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            head_last_q <= 1'b0;
            skid_last_q <= 1'b0;
        end else begin
            if (in_xfer) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (head_new) begin
                head_last_q <= in_last;
            end else if (head_from_skid) begin
                head_last_q <= skid_last_q;
            end
            if (skid_new) begin
                skid_last_q <= in_last;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sample_expander.sv
// Randomised and directed bench for sample_expander against a queue-based
// model; two instances (SHIFT=16 and SHIFT=4) share the same stimulus.
module tb_sample_expander;

    localparam int FFT_N = 16;

    typedef struct packed {
        logic [15:0] d;
        logic        last;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        m_ready;
    logic        s_ready, s_ready4;
    logic [31:0] m_data, m_data4;
    logic        m_valid, m_valid4;
`ifdef FRAME_LAST_EN
    logic        m_last, m_last4;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    ent_t q[$];
    int   in_cnt = 0;
    int   n_in = 0;
    int   out_idx = 0;
    int   last_log[$];
    bit   last_acc = 0;
    bit   ix, ox;

    always #5 clk = ~clk;

    sample_expander #(.FFT_N(FFT_N), .SHIFT(16)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
`ifdef FRAME_LAST_EN
        , .m_last(m_last)
`endif
    );

    sample_expander #(.FFT_N(FFT_N), .SHIFT(4)) dut4 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready4),
        .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready)
`ifdef FRAME_LAST_EN
        , .m_last(m_last4)
`endif
    );

    function automatic logic [31:0] widen(logic [15:0] d, int sh);
        logic [31:0] x;
        x = {{16{d[15]}}, d};
        return x << sh;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Reference model: a FIFO of at most two entries, updated at each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            in_cnt = 0;
            out_idx = 0;
            last_log.delete();
            last_acc = 0;
        end else begin
            ix = s_valid && (q.size() < 2);
            ox = m_ready && (q.size() > 0);
            last_acc = ix;
            if (ox) begin
`ifdef FRAME_LAST_EN
                if (m_last) last_log.push_back(out_idx);
`endif
                out_idx++;
                q.delete(0);
            end
            if (ix) begin
                q.push_back('{d: s_data, last: ((in_cnt % FFT_N) == FFT_N - 1)});
                in_cnt++;
                n_in++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_s_ready", {31'd0, s_ready}, 32'd0);
            check("rst_m_valid", {31'd0, m_valid}, 32'd0);
            check("rst_m_data", m_data, 32'd0);
        end else begin
            check("s_ready", {31'd0, s_ready}, {31'd0, q.size() < 2});
            check("s_ready4", {31'd0, s_ready4}, {31'd0, q.size() < 2});
            check("m_valid", {31'd0, m_valid}, {31'd0, q.size() > 0});
            check("m_valid4", {31'd0, m_valid4}, {31'd0, q.size() > 0});
            if (q.size() > 0) begin
                check("m_data_sh16", m_data, widen(q[0].d, 16));
                check("m_data_sh4", m_data4, widen(q[0].d, 4));
`ifdef FRAME_LAST_EN
                check("m_last", {31'd0, m_last}, {31'd0, q[0].last});
                check("m_last4", {31'd0, m_last4}, {31'd0, q[0].last});
`endif
            end
        end
    end

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        check("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        int k;
        int cyc;
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data = '0;
        #3;
        check("init_s_ready", {31'd0, s_ready}, 32'd0);
        check("init_m_valid", {31'd0, m_valid}, 32'd0);
        check("init_m_data", m_data, 32'd0);
        step();
        rst = 1'b0;
        #0;
        check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

        // Literal widening pins
        s_data = 16'h0001; s_valid = 1'b1; m_ready = 1'b1;
        step();
        check("pin_0001", m_data, 32'h0001_0000);
        check("pin_0001_valid", {31'd0, m_valid}, 32'd1);
        s_data = 16'h8000;
        step();
        check("pin_8000", m_data, 32'h8000_0000);
        s_data = 16'hFFFF;
        step();
        check("pin_ffff_sh4", m_data4, 32'hFFFF_FFF0);
        drain();

        // Continuous frame of 40 samples
        do_reset();
        s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            s_data = 16'(i);
            step();
        end
        drain();
`ifdef FRAME_LAST_EN
        check("last_count", last_log.size(), 32'd2);
        if (last_log.size() == 2) begin
            check("last_first", last_log[0], 32'd15);
            check("last_second", last_log[1], 32'd31);
        end
`endif

        // Backpressure: fill to FULL, hold, then release in order
        do_reset();
        m_ready = 1'b0; s_valid = 1'b1;
        s_data = 16'd0;
        step();
        s_data = 16'd1;
        step();
        check("full_s_ready", {31'd0, s_ready}, 32'd0);
        check("full_m_data", m_data, 32'd0);
        s_data = 16'd2;
        step();
        step();
        check("held_m_data", m_data, 32'd0);
        m_ready = 1'b1;
        k = 2;
        for (int i = 0; i < 12; i++) begin
            step();
            if (last_acc) begin
                k++;
                s_data = 16'(k);
            end
        end
        drain();
        check("bp_out_count", out_idx, in_cnt);

        // Random valid/ready, 1000 accepted samples
        do_reset();
        k = n_in;
        cyc = 0;
        while ((n_in - k) < 1000 && cyc < 20000) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_data = 16'($urandom);
            step();
            cyc++;
        end
        check("rand_accepted", n_in - k, 32'd1000);
        drain();
        check("rand_out_count", out_idx, in_cnt);

        // Async reset while FULL mid-frame
        do_reset();
        s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 16'(100 + i);
            step();
        end
        m_ready = 1'b0;
        step();
        step();
        check("pre_rst_full", {31'd0, s_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async_m_valid", {31'd0, m_valid}, 32'd0);
        check("async_s_ready", {31'd0, s_ready}, 32'd0);
        check("async_m_data", m_data, 32'd0);
        step();
        step();
        rst = 1'b0;
        s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_data = 16'(200 + i);
            step();
        end
        drain();
`ifdef FRAME_LAST_EN
        check("rst_last_count", last_log.size(), 32'd1);
        if (last_log.size() > 0) check("rst_last_idx", last_log[0], 32'd15);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
